// File: rtl/sum_rizado_sched_if.sv
// Bundle between the two requesters, the result consumer and the shared-adder sequencer.
// master = client/consumer side, slave = sequencer side.
interface sum_rizado_sched_if #(
    parameter int NBYTES = 4
) ();
    localparam int W = 8 * NBYTES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ci;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ci;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_s;
    logic         res_co;
    logic         res_id;

    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ci,
        output req1_valid, req1_a, req1_b, req1_ci,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_s, res_co, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ci,
        input  req1_valid, req1_a, req1_b, req1_ci,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_s, res_co, res_id, busy
    );
endinterface

// File: rtl/sum_rizado_sched.sv
// Round-robin sequencer sharing one 8-bit ripple-carry adder between two requesters;
// each W-bit add runs byte-serially LSB-first with the carry chained through a register.

module sum_rizado (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic c;

    // NOTE: blocking '=' here is intentional: c must carry bit i's result into bit i+1
    // within the same evaluation, which is exactly how the ripple chain behaves.
    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module sum_rizado_sched #(
    parameter int NBYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    sum_rizado_sched_if.slave  bus
);
    localparam int W = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t       state, state_next;
    logic [2:0]   cnt;
    logic         carry;
    logic         ptr;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] res_s;
    logic         res_co;
    logic         res_id;

    logic         any_valid, grant_id, accept, last_byte;
    logic [7:0]   byte_a, byte_b, sum_s;
    logic         sum_co;

    // The pointer only matters on a tie; a lone requester always wins.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
    assign accept    = (state == IDLE) & any_valid;
    assign last_byte = (cnt == 3'(NBYTES - 1));

    assign bus.req0_ready = accept & ~grant_id;
    assign bus.req1_ready = accept & grant_id;
    assign bus.res_valid  = (state == DONE);
    assign bus.res_s      = res_s;
    assign bus.res_co     = res_co;
    assign bus.res_id     = res_id;
    assign bus.busy       = (state != IDLE);

    // NOTE: every output of an always_comb gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt == 3'(k)) begin
                byte_a = op_a[8*k +: 8];
                byte_b = op_b[8*k +: 8];
            end
        end
    end

    sum_rizado u_adder (
        .a  (byte_a),
        .b  (byte_b),
        .ci (carry),
        .s  (sum_s),
        .co (sum_co)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)        state_next = ADD;
            ADD:     if (last_byte)     state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: operand registers carry no reset; they are only read after an accept
    // has loaded them, so clearing them would cost logic without changing behaviour.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= grant_id ? bus.req1_a : bus.req0_a;
            op_b <= grant_id ? bus.req1_b : bus.req0_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            carry  <= 1'b0;
            ptr    <= 1'b0;
            res_s  <= '0;
            res_co <= 1'b0;
            res_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry  <= grant_id ? bus.req1_ci : bus.req0_ci;
                        res_id <= grant_id;
                        ptr    <= ~grant_id;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    // Only the current byte lane is written; higher lanes keep old data.
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt == 3'(k)) res_s[8*k +: 8] <= sum_s;
                    end
                    carry <= sum_co;
                    cnt   <= cnt + 3'd1;
                    if (last_byte) res_co <= sum_co;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_rizado_sched.sv
// Directed and randomized self-checking bench for sum_rizado_sched (NBYTES=4).
module tb_sum_rizado_sched;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    sum_rizado_sched_if #(.NBYTES(NBYTES)) bus ();

    sum_rizado_sched #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [W:0]  sum;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit ci);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);
        bus.res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns the number of posedges until res_valid is seen.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!bus.res_valid) check({tag, "_timeout"}, 64'(bus.res_valid), 64'd1);
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    // Single request from one port with the other idle; called at a negedge in IDLE.
    task automatic single_op(input string tag, input bit id, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit ci,
                             input logic [W-1:0] exp_s, input bit exp_co);
        int lat;
        set_req(id, 1, a, b, ci);
        #1;
        check({tag, "_rdy0"}, 64'(bus.req0_ready), 64'(!id));
        check({tag, "_rdy1"}, 64'(bus.req1_ready), 64'(id));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rdy_one_cycle"}, 64'(bus.req0_ready | bus.req1_ready), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        set_req(id, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        wait_valid(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'(NBYTES));
        check({tag, "_s"}, 64'(bus.res_s), 64'(exp_s));
        check({tag, "_co"}, 64'(bus.res_co), 64'(exp_co));
        check({tag, "_id"}, 64'(bus.res_id), 64'(id));
        drain();
        check({tag, "_valid_drop"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int   lat;
        int   done_cnt;
        int   cyc;
        bit   mptr;
        bit   g;
        bit   rv[2];
        bit   acc_prev[2];
        bit   rci[2];
        bit   rdy[2];
        logic [W-1:0] ra[2];
        logic [W-1:0] rb[2];
        exp_t q[$];
        exp_t e;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy",  64'(bus.busy),      64'd0);
        check("rst_valid", 64'(bus.res_valid), 64'd0);
        check("rst_s",     64'(bus.res_s),     64'd0);
        check("rst_co",    64'(bus.res_co),    64'd0);
        check("rst_id",    64'(bus.res_id),    64'd0);

        // Carry ripple and full-chain cases.
        single_op("ripple", 0, 32'h0000_00FF, 32'h0000_0001, 0, 32'h0000_0100, 0);
        single_op("chain",  1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'h0000_0000, 1);
        single_op("msb",    0, 32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000, 1);

        // Both valid continuously: grants alternate starting with req0.
        do_reset();
        set_req(0, 1, 32'd1,  32'd2,  0);
        set_req(1, 1, 32'd10, 32'd20, 0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_rdy0", 64'(bus.req0_ready), 64'((i % 2) == 0));
            check("rr_rdy1", 64'(bus.req1_ready), 64'((i % 2) == 1));
            @(posedge clk);
            @(negedge clk);
            wait_valid("rr", lat);
            check("rr_done_rdy", 64'(bus.req0_ready | bus.req1_ready), 64'd0);
            check("rr_id", 64'(bus.res_id), 64'(i % 2));
            check("rr_s",  64'(bus.res_s),  ((i % 2) == 0) ? 64'd3 : 64'd30);
            @(posedge clk);
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);

        // Backpressure: result held for 5 cycles, req1 waiting meanwhile.
        do_reset();
        set_req(0, 1, 32'h0102_0304, 32'h1020_3040, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 0, '0, '0, 0);
        set_req(1, 1, 32'd5, 32'd6, 0);
        wait_valid("bp", lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_s",    64'(bus.res_s),  64'h1122_3345);
            check("bp_co",   64'(bus.res_co), 64'd0);
            check("bp_id",   64'(bus.res_id), 64'd0);
            check("bp_rdy",  64'(bus.req0_ready | bus.req1_ready), 64'd0);
            check("bp_busy", 64'(bus.busy),   64'd1);
            check("bp_valid", 64'(bus.res_valid), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        drain();
        check("bp_valid_drop", 64'(bus.res_valid), 64'd0);
        check("bp_next_rdy1",  64'(bus.req1_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 0, '0, '0, 0);
        wait_valid("bp2", lat);
        check("bp2_s",  64'(bus.res_s),  64'd11);
        check("bp2_id", 64'(bus.res_id), 64'd1);
        drain();

        // Reset in the middle of ADD at counter=2.
        set_req(1, 1, 32'hAAAA_AAAA, 32'h1111_1111, 0);
        #1;
        check("mid_rdy1", 64'(bus.req1_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 0, '0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",  64'(bus.busy),      64'd0);
        check("mid_valid", 64'(bus.res_valid), 64'd0);
        check("mid_s",     64'(bus.res_s),     64'd0);
        check("mid_co",    64'(bus.res_co),    64'd0);
        check("mid_id",    64'(bus.res_id),    64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("mid_no_result", 64'(bus.res_valid), 64'd0);
        end
        set_req(0, 1, 32'h1234_5678, 32'h1111_1111, 0);
        set_req(1, 1, 32'h0000_0001, 32'h0000_0001, 0);
        #1;
        check("mid_g_rdy0", 64'(bus.req0_ready), 64'd1);
        check("mid_g_rdy1", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);
        wait_valid("mid2", lat);
        check("mid2_s",  64'(bus.res_s),  64'h2345_6789);
        check("mid2_co", 64'(bus.res_co), 64'd0);
        check("mid2_id", 64'(bus.res_id), 64'd0);
        drain();

        // Random regression with a round-robin reference and an in-order scoreboard.
        do_reset();
        mptr     = 1'b0;
        done_cnt = 0;
        cyc      = 0;
        for (int r = 0; r < 2; r++) begin
            rv[r] = 0; acc_prev[r] = 0; rci[r] = 0; ra[r] = '0; rb[r] = '0;
        end
        while (done_cnt < 1000 && cyc < 40000) begin
            cyc++;
            for (int r = 0; r < 2; r++) begin
                if (acc_prev[r]) begin
                    rv[r] = 0;
                    ra[r] = $urandom;
                    rb[r] = $urandom;
                end
                if (!rv[r] && $urandom_range(0, 2) != 0) begin
                    rv[r]  = 1;
                    ra[r]  = $urandom;
                    rb[r]  = $urandom;
                    rci[r] = 1'($urandom_range(0, 1));
                end
                set_req(1'(r), rv[r], ra[r], rb[r], rci[r]);
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy[0] = bus.req0_ready;
            rdy[1] = bus.req1_ready;
            g = (rv[0] && rv[1]) ? mptr : rv[1];
            check("rnd_rdy0", 64'(rdy[0]), 64'(!bus.busy && (rv[0] || rv[1]) && !g));
            check("rnd_rdy1", 64'(rdy[1]), 64'(!bus.busy && (rv[0] || rv[1]) && g));
            for (int r = 0; r < 2; r++) begin
                acc_prev[r] = rv[r] && rdy[r];
                if (acc_prev[r]) begin
                    e.id  = 1'(r);
                    e.sum = {1'b0, ra[r]} + {1'b0, rb[r]} + 33'(rci[r]);
                    q.push_back(e);
                    mptr = ~1'(r);
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                if (q.size() == 0) begin
                    check("rnd_extra", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    check("rnd_sum", 64'({bus.res_co, bus.res_s}), 64'(e.sum));
                    check("rnd_id",  64'(bus.res_id), 64'(e.id));
                    done_cnt++;
                end
            end
            @(negedge clk);
        end
        check("rnd_count", 64'(done_cnt), 64'd1000);
        check("rnd_left",  64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sum_rizado_sched.md
Name: sum_rizado_sched

Overview:
Sequencer and arbiter that shares one 8-bit ripple-carry adder (SUM_RIZADO: a[7:0], b[7:0], ci in; s[7:0], co out) between two requesters. The adder is instantiated once inside this block. Each accepted request is a multi-byte add, executed byte-serially LSB-first, with the carry chained through a register. The block sits between two client ports and a single result port in the power-analysis datapath. It trades latency for one shared adder instance.

Parameters:
NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..8.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_a  in  W  requester 0 operand A.
req0_b  in  W  requester 0 operand B.
req0_ci  in  1  requester 0 carry-in.
req1_valid, req1_ready, req1_a, req1_b, req1_ci  same as requester 0, for requester 1.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_s  out  W  sum, bits [W-1:0].
res_co  out  1  carry out of the MSB byte.
res_id  out  1  requester that issued this result (0 or 1).
busy  out  1  high when state is not IDLE.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- State machine states:
  - IDLE: arbitrate.
  - ADD: byte-serial addition.
  - DONE: hold the result.
- Reset, effective at the edge where reset=1, regardless of current state:
  - state=IDLE, byte counter=0, carry register=0, priority pointer=0.
  - res_valid=0, res_s=0, res_co=0, res_id=0, busy=0.
  - An in-flight operation is discarded and no result is emitted for it.
- IDLE arbitration, combinational:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by the pointer is granted.
  - reqN_ready=1 only for the granted requester, and only in IDLE. Both readys are 0 in ADD and DONE.
- Accept edge (IDLE and granted valid):
  - Latch A, B, ci and id.
  - Pointer becomes the other requester (round-robin).
  - counter=0, state goes to ADD.
- ADD, cycle k (k = 0..NBYTES-1):
  - Adder inputs: a = A[8k+7:8k], b = B[8k+7:8k], ci = carry register. On k=0 the carry register holds the latched reqN_ci.
  - At the edge, res_s[8k+7:8k] <= adder s, carry register <= adder co, counter increments.
  - At k = NBYTES-1: res_co <= adder co and state goes to DONE.
- Latency:
  - res_valid=1 is visible in the cycle after the NBYTES-th edge following the accept edge. This is 4 edges for the default NBYTES.
  - res_valid is driven from state==DONE and is registered.
- DONE:
  - res_s, res_co and res_id are held stable while res_valid=1 and res_ready=0.
  - At the edge where res_ready=1, state goes to IDLE and res_valid drops.
  - No acceptance happens in DONE. The next accept is possible in the following IDLE cycle.
  - Minimum request-to-request spacing is NBYTES+2 cycles.
- res_s contents:
  - res_s is undefined-but-stable until DONE. Implement it as 0 after reset.
  - Bytes above the current counter keep their previous values during ADD.
- Width rule: the result is a modulo-2^W sum. The carry out of byte NBYTES-1 goes to res_co only.
- Inputs reqN_* may change freely after the accept edge. Only the latched copies are used.
- busy = (state != IDLE).

Test Plan:
- Carry ripple across bytes: reset, then req0 a=0x000000FF, b=0x00000001, ci=0. Required: req0_ready=1 for 1 cycle; res_valid after 4 edges; res_s=0x00000100, res_co=0, res_id=0.
- Full carry chain: req1 a=0xFFFFFFFF, b=0x00000000, ci=1. Required: res_s=0x00000000, res_co=1, res_id=1. Also check a=0x80000000 + b=0x80000000, ci=0 gives res_s=0, res_co=1.
- Simultaneous requests after reset, both valid continuously with distinct operands (req0 1+2, req1 10+20). Required: results alternate id 0,1,0,1 with res_s=3,30,3,30. A requester's ready is never high twice in a row while the other is waiting.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid. Required: res_s, res_co and res_id stay constant; both readys stay 0; busy=1. Then res_ready=1 for one cycle gives res_valid=0 and the next accept one cycle later.
- Reset mid-operation: assert reset during ADD at counter=2. Required: the next cycle shows busy=0, res_valid=0, res_s=0, and no result is emitted. With both valid, the next transaction grants req0 and computes 0x12345678 + 0x11111111 = 0x23456789, res_co=0.
- Random regression: 1000 random operand pairs and carry-ins on random valid/ready patterns. Required: each result equals the golden {co,s} = a+b+ci and carries the correct res_id, with no lost or duplicated transactions.
